// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

  // Bytes that make up one instruction word.
  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the byte stream; the memory port is write-only.
interface imem_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Byte producer that also observes the memory writes.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // The loader: consumes bytes, drives the memory write port.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts bytes into a word register at the LSB end and counts bytes within the word.
// Latency: word updates on the edge a byte is shifted in.
// Backpressure: none; the caller decides when to shift or clear.
module word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_i,
  input  logic              shift_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);
  import imem_pkg::*;

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  // High while the next shifted byte completes the word.
  assign last_o = (cnt_q == CNT_W'(NBYTES - 1));
  assign word_o = word_q;

  // Clear wins over shift; the counter wraps after the last byte of a word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = (word_q << 8) | DATA_W'(byte_i);
      cnt_d  = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Word and byte-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a header-prefixed byte stream into instruction memory while holding the CPU.
// Latency: mem_we one cycle after the last byte of a word; done one cycle after the final write.
// Backpressure: in_ready only in HDR/DATA and never while abort is high; in_valid low stalls.
module imem_loader #(
  parameter int ADDR_W    = imem_pkg::ADDR_W,
  parameter int DATA_W    = imem_pkg::DATA_W,
  parameter int MAX_WORDS = imem_pkg::MAX_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);
  import imem_pkg::*;

  // One extra index bit so a full-depth load reaches N without wrapping to 0.
  localparam int IDX_W = ADDR_W + 1;

  ld_state_e         state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic              err_q, err_d;
  logic              shift, clr, last;
  logic              rdy, we, done_p, hold;
  logic [DATA_W-1:0] word;

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .byte_i (bus.in_data),
    .shift_i(shift),
    .clr_i  (clr),
    .word_o (word),
    .last_o (last)
  );

  assign idx_inc       = idx_q + 1'b1;
  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = idx_q[ADDR_W-1:0];
  assign bus.mem_wdata = word;
  assign cpu_hold      = hold;
  assign done          = done_p;
  assign err           = err_q;

  // Next-state and outputs; abort overrides everything the state would do.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = err_q;
    shift   = 1'b0;
    clr     = 1'b0;
    rdy     = 1'b0;
    we      = 1'b0;
    done_p  = 1'b0;
    hold    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        hold = 1'b0;
        if (start) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
          idx_d   = '0;
          n_d     = '0;
          clr     = 1'b1;
        end
      end
      ST_HDR: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          n_d = bus.in_data;
          if (bus.in_data == 8'd0) begin
            state_d = ST_DONE;
          end else if (int'(bus.in_data) > MAX_WORDS) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          shift = 1'b1;
          if (last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we      = 1'b1;
        idx_d   = idx_inc;
        clr     = 1'b1;
        state_d = (idx_inc == IDX_W'(n_q)) ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        done_p  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      n_d     = n_q;
      idx_d   = idx_q;
      err_d   = err_q;
      shift   = 1'b0;
      clr     = 1'b1;
      rdy     = 1'b0;
      we      = 1'b0;
      done_p  = 1'b0;
    end
  end

  // State, header count, word index and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table plus hand-written corner sequences.
// Expected writes go to a scoreboard queue when stimulus is driven; a monitor pops them.
// Driver acts just after rising edges; monitor and handshake sampling use falling edges.
module tb_imem_loader;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [7:0]  hdr;
    logic [3:0]  nb;
    logic [63:0] dat;
    logic [1:0]  gap;
    logic [1:0]  nw;
    logic [63:0] w;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cpu_hold, done, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_we = 0;
  int n_done = 0;
  int we_cyc = 0;
  int done_cyc = 0;
  int last_acc = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  vec_t vt[7];

  imem_loader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(5), .DATA_W(32), .MAX_WORDS(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor for memory writes and done pulses.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      n_we++;
      we_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h want no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(mon_e.a));
        chk("wr_data", 64'(bus.mem_wdata), 64'(mon_e.d));
      end
    end
    if (rst_n && done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] bval(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t t;
    t.a = 5'(a);
    t.d = d;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic gap_wait(input int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the handshake completes (bounded).
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        last_acc = cyc;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int w0, d0, hdr_cyc;
    t = vt[v];
    w0 = n_we;
    d0 = n_done;
    for (int k = 0; k < int'(t.nw); k++) push_wr(k, t.w[63-32*k -: 32]);
    pulse_start();
    send_byte(t.hdr);
    hdr_cyc = last_acc;
    if (t.nw > 0) chk("hold_in_load", 64'(cpu_hold), 64'd1);
    for (int j = 0; j < int'(t.nb); j++) begin
      if (t.gap > 0) gap_wait(int'(t.gap));
      send_byte(t.dat[63-8*j -: 8]);
    end
    settle();
    chk("n_writes", 64'(n_we - w0), 64'(t.nw));
    chk("n_done", 64'(n_done - d0), 64'(t.exp_done));
    chk("err", 64'(err), 64'(t.exp_err));
    chk("hold_idle", 64'(cpu_hold), 64'd0);
    chk("rdy_idle", 64'(bus.in_ready), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    if (t.nw > 0) chk("we_latency", 64'(we_cyc), 64'(last_acc + 1));
    if (t.exp_done) chk("done_latency", 64'(done_cyc), (t.nw > 0) ? 64'(we_cyc + 1) : 64'(hdr_cyc + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0;
    vt[0] = '{hdr:8'h01, nb:4'd4, dat:64'h00000800_00000000, gap:2'd0, nw:2'd1,
              w:64'h00000800_00000000, exp_done:1'b1, exp_err:1'b0};
    vt[1] = '{hdr:8'h02, nb:4'd8, dat:64'h2402000B_8C230000, gap:2'd3, nw:2'd2,
              w:64'h2402000B_8C230000, exp_done:1'b1, exp_err:1'b0};
    vt[2] = '{hdr:8'h00, nb:4'd0, dat:64'h0, gap:2'd0, nw:2'd0,
              w:64'h0, exp_done:1'b1, exp_err:1'b0};
    vt[3] = '{hdr:8'h21, nb:4'd0, dat:64'h0, gap:2'd0, nw:2'd0,
              w:64'h0, exp_done:1'b0, exp_err:1'b1};
    vt[4] = '{hdr:8'h01, nb:4'd4, dat:64'hDEADBEEF_00000000, gap:2'd1, nw:2'd1,
              w:64'hDEADBEEF_00000000, exp_done:1'b1, exp_err:1'b0};
    vt[5] = '{hdr:8'hFF, nb:4'd0, dat:64'h0, gap:2'd0, nw:2'd0,
              w:64'h0, exp_done:1'b0, exp_err:1'b1};
    vt[6] = '{hdr:8'h02, nb:4'd8, dat:64'h01234567_89ABCDEF, gap:2'd0, nw:2'd2,
              w:64'h01234567_89ABCDEF, exp_done:1'b1, exp_err:1'b0};

    // Reset state, with a byte offered that must not be taken.
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) run_vec(v);

    // err is sticky through abort; abort beats start in IDLE.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    chk("err_after_abort", 64'(err), 64'd1);
    chk("abort_beats_start", 64'(cpu_hold), 64'd0);

    for (int v = 4; v < 7; v++) run_vec(v);

    // Full-depth load with an ignored start pulse in the middle.
    w0 = n_we;
    d0 = n_done;
    for (int k = 0; k < 32; k++)
      push_wr(k, {bval(4*k), bval(4*k+1), bval(4*k+2), bval(4*k+3)});
    pulse_start();
    send_byte(8'h20);
    for (int i = 0; i < 128; i++) begin
      if (i == 10) pulse_start();
      send_byte(bval(i));
    end
    settle();
    chk("full_writes", 64'(n_we - w0), 64'd32);
    chk("full_done", 64'(n_done - d0), 64'd1);
    chk("full_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("full_hold", 64'(cpu_hold), 64'd0);

    // Abort mid-word, with a byte offered during the abort cycle.
    w0 = n_we;
    d0 = n_done;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.in_data  = 8'h33;
    bus.in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_rdy_gate", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_rdy", 64'(bus.in_ready), 64'd0);
    chk("abort_hold", 64'(cpu_hold), 64'd0);
    settle();
    chk("abort_no_we", 64'(n_we - w0), 64'd0);
    chk("abort_no_done", 64'(n_done - d0), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    run_vec(0);

    // Reset mid-word: outputs drop without waiting for a clock edge.
    w0 = n_we;
    d0 = n_done;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_hold", 64'(cpu_hold), 64'd0);
    chk("mrst_rdy", 64'(bus.in_ready), 64'd0);
    chk("mrst_we", 64'(bus.mem_we), 64'd0);
    chk("mrst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_no_we", 64'(n_we - w0), 64'd0);
    chk("mrst_no_done", 64'(n_done - d0), 64'd0);
    run_vec(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
